game_flow_ctrl: RTL and testbench
=================================

# game_flow_ctrl

Top-level game-flow sequencer for the bomb game: it steps through waiting, setup, playing, won and lost, and drives the countdown timer, the bomb-logic modules and the 16-character status display. It is the parametrised successor to the fixed game FSM. It adds a configurable number of puzzle modules with a per-module solved mask, a strike counter with a configurable loss limit, timer-expiry loss and rising-edge button detection. It sits between the debounced user buttons, the timer, the bomb-logic modules and the display driver.

## Interface
- NUM_MODULES, 4, number of puzzle modules (1–8)
- MAX_STRIKES, 3, strikes that cause a loss (1–9)
- STRIKE_W, $clog2(MAX_STRIKES+1), strike counter width (derived)

- clock  in  1  65 MHz game clock
- reset  in  1  synchronous, active-high
- start_game  in  1  debounced level; a rising edge requests play
- setup_complete  in  1  debounced level; a rising edge ends setup
- module_solved  in  NUM_MODULES  per-module solved level
- strike  in  NUM_MODULES  per-module one-cycle error pulse
- timer_expired  in  1  level from the countdown timer
- ascii_timer  in  24  ASCII m, s, s digits
- begin_setup  out  1  one-cycle pulse to bomb-logic
- begin_timer  out  1  one-cycle pulse to the timer
- enable  out  1  high only in PLAYING
- explode  out  1  one-cycle pulse on entry to LOST
- state  out  3  current state encoding
- strikes  out  STRIKE_W  current strike count
- solved_mask  out  NUM_MODULES  sticky solved flags
- string_data  out  128  16 ASCII chars, MSB is the first char

## Operation
- States and encodings:
  - WAITING = 000
  - SETUP = 001
  - PLAYING = 100
  - WON = 010
  - LOST = 011
  - Undefined encodings go to WAITING on the next cycle.
- Edge detect: `start_rise = start_game & ~start_d`, same for setup. The delay regs reset to 0.
- WAITING, WON, LOST: on start_rise go to SETUP and pulse begin_setup. Entering SETUP clears strikes and solved_mask.
- SETUP: on setup_rise go to PLAYING and pulse begin_timer.
- PLAYING:
  - `solved_mask |= module_solved` each cycle.
  - `strikes_next = min(strikes + popcount(strike), MAX_STRIKES)`; the count saturates.
  - Go to LOST if strikes_next == MAX_STRIKES or timer_expired.
  - Else go to WON if (solved_mask | module_solved) is all ones.
  - Loss has priority over a simultaneous win.
- Outside PLAYING, the strike and module_solved inputs are ignored. strikes and solved_mask hold their values for display after the game ends.
- string_data, exactly 16 chars each:
  - WAITING: " Want to play?  "
  - SETUP: " set up the bomb"
  - PLAYING: "T-" m ":" ss " STRK " digit(strikes) "/" digit(MAX_STRIKES) " "
  - WON: "  game won!! :) "
  - LOST: "  game lost :(  "
- Reset values:
  - state = WAITING
  - all pulses = 0, enable = 0
  - strikes = 0, solved_mask = 0
  - string_data = the WAITING string
  - reset overrides every transition, including one mid-game.

## Timing
- All outputs are registered.
- An input event sampled at edge n is reflected in state and outputs after edge n (latency 1).
- begin_setup and begin_timer are high for exactly the first cycle of SETUP and PLAYING respectively.
- explode is high for exactly the first cycle of LOST.
- enable rises with the first PLAYING cycle and falls with the first cycle after PLAYING.
- A start_game held high does not retrigger; a new rising edge is needed.
- setup_rise outside SETUP is ignored.
- A strike on the final cycle of PLAYING is counted, since the transition uses strikes_next.

## Structure
- Package game_pkg holds:
  - the state encodings
  - the four fixed 128-bit string constants
  - a digit-to-ASCII function
- Sub-module rise_detect is instantiated once for start_game and once for setup_complete. It contains one register with synchronous reset, and its output is `in & ~in_d`.

## Test plan
- Reset, then a start_game rise: SETUP next cycle, begin_setup = 1 for 1 cycle, strikes = 0. A held start_game produces no second pulse.
- setup_complete rise, then module_solved = 4'b0001, 4'b0010, 4'b0100, 4'b1000 on separate cycles: WON one cycle after the last, enable low, solved_mask = 4'b1111.
- In PLAYING, strike = 4'b0001 three times: strikes goes 1, 2, 3; LOST with explode pulse on the third. The PLAYING string shows "STRK 2/3" before it.
- strike = 4'b0110 when strikes = 2: saturates at 3, goes to LOST.
- Last module solved in the same cycle as timer_expired: goes to LOST, not WON.
- Reset asserted mid-PLAYING with strikes = 2: the next cycle shows state = 000, enable = 0, strikes = 0 and the WAITING string.

Source files
------------

// File: rtl/game_pkg.sv
// Shared definitions for the bomb-game flow sequencer: state encodings,
// fixed status-display strings and ASCII helpers.
package game_pkg;

    localparam logic [2:0] ST_WAITING = 3'b000;
    localparam logic [2:0] ST_SETUP   = 3'b001;
    localparam logic [2:0] ST_PLAYING = 3'b100;
    localparam logic [2:0] ST_WON     = 3'b010;
    localparam logic [2:0] ST_LOST    = 3'b011;

    // Each string is exactly 16 characters; the first character sits in the MSBs.
    localparam logic [127:0] STR_WAITING = " Want to play?  ";
    localparam logic [127:0] STR_SETUP   = " set up the bomb";
    localparam logic [127:0] STR_WON     = "  game won!! :) ";
    localparam logic [127:0] STR_LOST    = "  game lost :(  ";

    function automatic logic [7:0] digit_ascii(input logic [3:0] digit);
        return 8'h30 + {4'h0, digit};
    endfunction

endpackage

// File: rtl/rise_detect.sv
// Rising-edge detector for a debounced level: one cycle high when the level
// goes from 0 to 1 relative to the previous cycle.
module rise_detect (
    input  logic clock,
    input  logic reset,
    input  logic level,
    output logic rise
);

    logic level_d;

    // NOTE: sequential state always uses non-blocking assignments so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge clock) begin
        if (reset) begin
            level_d <= 1'b0;
        end else begin
            level_d <= level;
        end
    end

    assign rise = level & ~level_d;

endmodule

// File: rtl/game_flow_ctrl.sv
// Bomb-game flow sequencer: waiting -> setup -> playing -> won/lost, with a
// saturating strike counter, sticky solved mask and registered status text.
module game_flow_ctrl
    import game_pkg::*;
#(
    parameter int NUM_MODULES = 4,
    parameter int MAX_STRIKES = 3,
    parameter int STRIKE_W    = $clog2(MAX_STRIKES + 1)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start_game,
    input  logic                   setup_complete,
    input  logic [NUM_MODULES-1:0] module_solved,
    input  logic [NUM_MODULES-1:0] strike,
    input  logic                   timer_expired,
    input  logic [23:0]            ascii_timer,
    output logic                   begin_setup,
    output logic                   begin_timer,
    output logic                   enable,
    output logic                   explode,
    output logic [2:0]             state,
    output logic [STRIKE_W-1:0]    strikes,
    output logic [NUM_MODULES-1:0] solved_mask,
    output logic [127:0]           string_data
);

    logic                   start_rise;
    logic                   setup_rise;
    logic [2:0]             state_nx;
    logic [STRIKE_W-1:0]    strikes_nx;
    logic [STRIKE_W-1:0]    strikes_play;
    logic [NUM_MODULES-1:0] solved_nx;
    logic [NUM_MODULES-1:0] solved_play;
    logic [3:0]             strike_hits;
    logic [4:0]             strike_sum;
    logic [127:0]           string_nx;

    rise_detect u_start_rise (
        .clock (clock),
        .reset (reset),
        .level (start_game),
        .rise  (start_rise)
    );

    rise_detect u_setup_rise (
        .clock (clock),
        .reset (reset),
        .level (setup_complete),
        .rise  (setup_rise)
    );

    // Strike count this cycle would reach if we are playing; saturates at the limit.
    always_comb begin
        // NOTE: every combinational output gets a default before any branch,
        // so no path leaves a value unassigned and no latch is inferred.
        strike_hits = '0;
        for (int i = 0; i < NUM_MODULES; i++) begin
            strike_hits = strike_hits + {3'b000, strike[i]};
        end
        strike_sum   = 5'(strikes) + {1'b0, strike_hits};
        strikes_play = (strike_sum >= 5'(MAX_STRIKES)) ? STRIKE_W'(MAX_STRIKES)
                                                       : STRIKE_W'(strike_sum);
        solved_play  = solved_mask | module_solved;
    end

    always_comb begin
        state_nx   = state;
        strikes_nx = strikes;
        solved_nx  = solved_mask;
        case (state)
            ST_WAITING, ST_WON, ST_LOST: begin
                if (start_rise) begin
                    state_nx   = ST_SETUP;
                    strikes_nx = '0;
                    solved_nx  = '0;
                end
            end
            ST_SETUP: begin
                if (setup_rise) begin
                    state_nx = ST_PLAYING;
                end
            end
            ST_PLAYING: begin
                strikes_nx = strikes_play;
                solved_nx  = solved_play;
                // Loss is checked first so it wins over a same-cycle full solve.
                if (strikes_play == STRIKE_W'(MAX_STRIKES) || timer_expired) begin
                    state_nx = ST_LOST;
                end else if (&solved_play) begin
                    state_nx = ST_WON;
                end
            end
            default: state_nx = ST_WAITING;
        endcase
    end

    // Text is built from next-cycle values so it lands together with the state.
    always_comb begin
        string_nx = STR_WAITING;
        case (state_nx)
            ST_SETUP:   string_nx = STR_SETUP;
            ST_WON:     string_nx = STR_WON;
            ST_LOST:    string_nx = STR_LOST;
            ST_PLAYING: string_nx = {"T-", ascii_timer[23:16], ":", ascii_timer[15:0],
                                     " STRK ", digit_ascii(4'(strikes_nx)), "/",
                                     digit_ascii(4'(MAX_STRIKES)), " "};
            default:    string_nx = STR_WAITING;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= ST_WAITING;
            strikes     <= '0;
            solved_mask <= '0;
            begin_setup <= 1'b0;
            begin_timer <= 1'b0;
            enable      <= 1'b0;
            explode     <= 1'b0;
            string_data <= STR_WAITING;
        end else begin
            state       <= state_nx;
            strikes     <= strikes_nx;
            solved_mask <= solved_nx;
            begin_setup <= (state_nx == ST_SETUP)   && (state != ST_SETUP);
            begin_timer <= (state_nx == ST_PLAYING) && (state != ST_PLAYING);
            enable      <= (state_nx == ST_PLAYING);
            explode     <= (state_nx == ST_LOST)    && (state != ST_LOST);
            string_data <= string_nx;
        end
    end

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Scoreboard bench for game_flow_ctrl: directed steps push hand-computed
// expectations; a monitor compares them one cycle later.
module tb_game_flow_ctrl;

    typedef struct packed {
        logic [2:0]   st;
        logic         bs;
        logic         bt;
        logic         en;
        logic         ex;
        logic [1:0]   stk;
        logic [3:0]   msk;
        logic [127:0] str;
    } exp_t;

    localparam logic [2:0] WAIT = 3'b000;
    localparam logic [2:0] SETP = 3'b001;
    localparam logic [2:0] PLAY = 3'b100;
    localparam logic [2:0] WON  = 3'b010;
    localparam logic [2:0] LOST = 3'b011;

    localparam logic [127:0] S_WAIT = " Want to play?  ";
    localparam logic [127:0] S_SETP = " set up the bomb";
    localparam logic [127:0] S_WON  = "  game won!! :) ";
    localparam logic [127:0] S_LOST = "  game lost :(  ";
    localparam logic [127:0] P0_530 = "T-5:30 STRK 0/3 ";
    localparam logic [127:0] P1_530 = "T-5:30 STRK 1/3 ";
    localparam logic [127:0] P0_459 = "T-4:59 STRK 0/3 ";
    localparam logic [127:0] P1_459 = "T-4:59 STRK 1/3 ";
    localparam logic [127:0] P2_459 = "T-4:59 STRK 2/3 ";
    localparam logic [23:0]  T530   = "530";
    localparam logic [23:0]  T459   = "459";

    logic         clock;
    logic         reset;
    logic         start_game;
    logic         setup_complete;
    logic [3:0]   module_solved;
    logic [3:0]   strike;
    logic         timer_expired;
    logic [23:0]  ascii_timer;
    logic         begin_setup;
    logic         begin_timer;
    logic         enable;
    logic         explode;
    logic [2:0]   state;
    logic [1:0]   strikes;
    logic [3:0]   solved_mask;
    logic [127:0] string_data;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   mon_idx = 0;

    game_flow_ctrl #(.NUM_MODULES(4), .MAX_STRIKES(3)) dut (
        .clock          (clock),
        .reset          (reset),
        .start_game     (start_game),
        .setup_complete (setup_complete),
        .module_solved  (module_solved),
        .strike         (strike),
        .timer_expired  (timer_expired),
        .ascii_timer    (ascii_timer),
        .begin_setup    (begin_setup),
        .begin_timer    (begin_timer),
        .enable         (enable),
        .explode        (explode),
        .state          (state),
        .strikes        (strikes),
        .solved_mask    (solved_mask),
        .string_data    (string_data)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %h required %h", name, mon_idx, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [2:0] st, input logic bs, input logic bt,
                                input logic en, input logic ex, input logic [1:0] stk,
                                input logic [3:0] msk, input logic [127:0] str);
        exp_t e;
        e.st = st; e.bs = bs; e.bt = bt; e.en = en; e.ex = ex;
        e.stk = stk; e.msk = msk; e.str = str;
        return e;
    endfunction

    // Drive one cycle of inputs and queue what the outputs must be after the next edge.
    task automatic step(input logic r, input logic sg, input logic sc,
                        input logic [3:0] ms, input logic [3:0] sk, input logic te,
                        input logic [23:0] tm, input exp_t e);
        @(negedge clock);
        reset          = r;
        start_game     = sg;
        setup_complete = sc;
        module_solved  = ms;
        strike         = sk;
        timer_expired  = te;
        ascii_timer    = tm;
        exp_q.push_back(e);
    endtask

    // Monitor: outputs are valid every cycle; compare whenever an expectation is pending.
    initial begin
        forever begin
            @(posedge clock);
            #1;
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                mon_idx++;
                check("state",       128'(state),       128'(mon_e.st));
                check("begin_setup", 128'(begin_setup), 128'(mon_e.bs));
                check("begin_timer", 128'(begin_timer), 128'(mon_e.bt));
                check("enable",      128'(enable),      128'(mon_e.en));
                check("explode",     128'(explode),     128'(mon_e.ex));
                check("strikes",     128'(strikes),     128'(mon_e.stk));
                check("solved_mask", 128'(solved_mask), 128'(mon_e.msk));
                check("string_data", string_data,       mon_e.str);
            end
        end
    end

    initial begin
        reset = 1'b1; start_game = 1'b0; setup_complete = 1'b0;
        module_solved = '0; strike = '0; timer_expired = 1'b0; ascii_timer = T530;

        // Reset, start rise, held start, inputs ignored in SETUP.
        step(1, 0, 0, 4'h0, 4'h0, 0, T530, mk(WAIT, 0, 0, 0, 0, 0, 4'h0, S_WAIT));
        step(0, 0, 0, 4'h0, 4'h0, 0, T530, mk(WAIT, 0, 0, 0, 0, 0, 4'h0, S_WAIT));
        step(0, 1, 0, 4'h0, 4'h0, 0, T530, mk(SETP, 1, 0, 0, 0, 0, 4'h0, S_SETP));
        step(0, 1, 0, 4'h0, 4'h0, 0, T530, mk(SETP, 0, 0, 0, 0, 0, 4'h0, S_SETP));
        step(0, 1, 0, 4'hF, 4'h1, 0, T530, mk(SETP, 0, 0, 0, 0, 0, 4'h0, S_SETP));
        // Win by solving modules one at a time.
        step(0, 0, 1, 4'h0, 4'h0, 0, T530, mk(PLAY, 0, 1, 1, 0, 0, 4'h0, P0_530));
        step(0, 0, 1, 4'h1, 4'h0, 0, T530, mk(PLAY, 0, 0, 1, 0, 0, 4'h1, P0_530));
        step(0, 0, 0, 4'h2, 4'h0, 0, T530, mk(PLAY, 0, 0, 1, 0, 0, 4'h3, P0_530));
        step(0, 0, 0, 4'h4, 4'h0, 0, T530, mk(PLAY, 0, 0, 1, 0, 0, 4'h7, P0_530));
        step(0, 0, 0, 4'h8, 4'h0, 0, T530, mk(WON,  0, 0, 0, 0, 0, 4'hF, S_WON));
        // Setup rise and strikes outside their states are ignored.
        step(0, 0, 0, 4'h0, 4'h0, 0, T530, mk(WON,  0, 0, 0, 0, 0, 4'hF, S_WON));
        step(0, 0, 1, 4'h0, 4'h1, 0, T530, mk(WON,  0, 0, 0, 0, 0, 4'hF, S_WON));
        // New game clears counters; three single strikes lose.
        step(0, 1, 0, 4'h0, 4'h0, 0, T530, mk(SETP, 1, 0, 0, 0, 0, 4'h0, S_SETP));
        step(0, 0, 1, 4'h0, 4'h0, 0, T530, mk(PLAY, 0, 1, 1, 0, 0, 4'h0, P0_530));
        step(0, 0, 0, 4'h0, 4'h1, 0, T530, mk(PLAY, 0, 0, 1, 0, 1, 4'h0, P1_530));
        step(0, 0, 0, 4'h0, 4'h0, 0, T530, mk(PLAY, 0, 0, 1, 0, 1, 4'h0, P1_530));
        step(0, 0, 0, 4'h0, 4'h1, 0, T459, mk(PLAY, 0, 0, 1, 0, 2, 4'h0, P2_459));
        step(0, 0, 0, 4'h0, 4'h1, 0, T459, mk(LOST, 0, 0, 0, 1, 3, 4'h0, S_LOST));
        step(0, 0, 0, 4'h0, 4'h0, 0, T459, mk(LOST, 0, 0, 0, 0, 3, 4'h0, S_LOST));
        // Multi-strike saturation.
        step(0, 1, 0, 4'h0, 4'h0, 0, T459, mk(SETP, 1, 0, 0, 0, 0, 4'h0, S_SETP));
        step(0, 0, 1, 4'h0, 4'h0, 0, T459, mk(PLAY, 0, 1, 1, 0, 0, 4'h0, P0_459));
        step(0, 0, 0, 4'h0, 4'h2, 0, T459, mk(PLAY, 0, 0, 1, 0, 1, 4'h0, P1_459));
        step(0, 0, 0, 4'h0, 4'h4, 0, T459, mk(PLAY, 0, 0, 1, 0, 2, 4'h0, P2_459));
        step(0, 0, 0, 4'h0, 4'h6, 0, T459, mk(LOST, 0, 0, 0, 1, 3, 4'h0, S_LOST));
        // Last module solved together with timer expiry: loss wins.
        step(0, 1, 0, 4'h0, 4'h0, 0, T459, mk(SETP, 1, 0, 0, 0, 0, 4'h0, S_SETP));
        step(0, 0, 1, 4'h0, 4'h0, 0, T459, mk(PLAY, 0, 1, 1, 0, 0, 4'h0, P0_459));
        step(0, 0, 0, 4'h7, 4'h0, 0, T459, mk(PLAY, 0, 0, 1, 0, 0, 4'h7, P0_459));
        step(0, 0, 0, 4'h8, 4'h0, 1, T459, mk(LOST, 0, 0, 0, 1, 0, 4'hF, S_LOST));
        step(0, 0, 0, 4'h0, 4'h0, 0, T459, mk(LOST, 0, 0, 0, 0, 0, 4'hF, S_LOST));
        // Reset mid-game with two strikes.
        step(0, 1, 0, 4'h0, 4'h0, 0, T459, mk(SETP, 1, 0, 0, 0, 0, 4'h0, S_SETP));
        step(0, 0, 1, 4'h0, 4'h0, 0, T459, mk(PLAY, 0, 1, 1, 0, 0, 4'h0, P0_459));
        step(0, 0, 0, 4'h0, 4'h3, 0, T459, mk(PLAY, 0, 0, 1, 0, 2, 4'h0, P2_459));
        step(1, 0, 0, 4'h0, 4'h0, 0, T459, mk(WAIT, 0, 0, 0, 0, 0, 4'h0, S_WAIT));
        step(0, 0, 0, 4'h0, 4'h0, 0, T459, mk(WAIT, 0, 0, 0, 0, 0, 4'h0, S_WAIT));

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) begin
            @(posedge clock);
            #2;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expectations required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
